// File: rtl/rv64_immediate_extender_if.sv
// ----------------------------------------------------------------------------
// rv64_immediate_extender_if
//   Groups the signals between the decode stage and the immediate generator.
//   The decoder side drives the instruction. The generator side returns the
//   extended immediate and its format tag one cycle later.
//
//   in_valid     decoder -> generator  instruction is valid this cycle
//   instruction  decoder -> generator  32-bit instruction word
//   out_valid    generator -> decoder  immediate/imm_type valid
//   immediate    generator -> decoder  XLEN-bit extended immediate
//   imm_type     generator -> decoder  format tag (NONE,I,S,B,U,J,SHAMT,CSR_Z)
//
//   Modports:
//     master  the decode-stage side; drives the instruction
//     slave   the immediate generator
// ----------------------------------------------------------------------------
interface rv64_immediate_extender_if #(
    parameter int XLEN = 64,
    parameter int ILEN = 32
);
    logic            in_valid;
    logic [ILEN-1:0] instruction;
    logic            out_valid;
    logic [XLEN-1:0] immediate;
    logic [2:0]      imm_type;

    modport master (
        output in_valid,
        output instruction,
        input  out_valid,
        input  immediate,
        input  imm_type
    );

    modport slave (
        input  in_valid,
        input  instruction,
        output out_valid,
        output immediate,
        output imm_type
    );
endinterface

// File: rtl/rv64_immediate_extender.sv
// ----------------------------------------------------------------------------
// rv64_immediate_extender
//   Registered RV64I immediate generator for the decode stage. It selects the
//   immediate format from the opcode, and also from funct3 for shifts and
//   SYSTEM instructions. It produces a 64-bit sign- or zero-extended immediate
//   and a format tag, with one cycle of latency.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset; clears out_valid, immediate and
//            imm_type
//     bus    slave side of rv64_immediate_extender_if
//            (in_valid/instruction in; out_valid/immediate/imm_type out)
//
//   Format tags: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 CSR_Z.
//   When in_valid is low, immediate and imm_type hold their values and
//   out_valid drops.
// ----------------------------------------------------------------------------
module rv64_immediate_extender #(
    parameter int XLEN = 64,
    parameter int ILEN = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    rv64_immediate_extender_if.slave    bus
);

    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_S     = 3'd2,
        IMM_B     = 3'd3,
        IMM_U     = 3'd4,
        IMM_J     = 3'd5,
        IMM_SHAMT = 3'd6,
        IMM_CSR_Z = 3'd7
    } imm_type_e;

    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OP_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC     = 7'b0010111;
    localparam logic [6:0] OP_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_LUI       = 7'b0110111;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM    = 7'b1110011;

    logic [ILEN-1:0] inst;
    logic [6:0]      op;
    logic [2:0]      f3;
    logic            is_shift;

    assign inst     = bus.instruction;
    assign op       = inst[6:0];
    assign f3       = inst[14:12];
    // SLLI/SRLI/SRAI and their -W forms use funct3 001 and 101.
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    // Candidate immediates for each format, already extended to XLEN.
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] imm_shamt64, imm_shamt32, imm_csr_z;

    assign imm_i       = {{(XLEN-12){inst[31]}}, inst[31:20]};
    assign imm_s       = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b       = {{(XLEN-13){inst[31]}}, inst[31], inst[7],
                          inst[30:25], inst[11:8], 1'b0};
    assign imm_u       = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
    assign imm_j       = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12],
                          inst[20], inst[30:21], 1'b0};
    // Shift amounts take only the shamt field. The funct6/funct7 bits,
    // such as the SRAI bit 30, are excluded.
    assign imm_shamt64 = {{(XLEN-6){1'b0}}, inst[25:20]};
    assign imm_shamt32 = {{(XLEN-5){1'b0}}, inst[24:20]};
    assign imm_csr_z   = {{(XLEN-5){1'b0}}, inst[19:15]};

    logic [XLEN-1:0] dec_imm;
    imm_type_e       dec_type;

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves it unassigned and infers a latch.
    always_comb begin
        dec_imm  = '0;
        dec_type = IMM_NONE;
        unique case (op)
            OP_LOAD, OP_MISC_MEM, OP_JALR: begin
                dec_imm  = imm_i;
                dec_type = IMM_I;
            end
            OP_OP_IMM: begin
                dec_imm  = is_shift ? imm_shamt64 : imm_i;
                dec_type = is_shift ? IMM_SHAMT   : IMM_I;
            end
            OP_OP_IMM_32: begin
                dec_imm  = is_shift ? imm_shamt32 : imm_i;
                dec_type = is_shift ? IMM_SHAMT   : IMM_I;
            end
            OP_STORE: begin
                dec_imm  = imm_s;
                dec_type = IMM_S;
            end
            OP_BRANCH: begin
                dec_imm  = imm_b;
                dec_type = IMM_B;
            end
            OP_LUI, OP_AUIPC: begin
                dec_imm  = imm_u;
                dec_type = IMM_U;
            end
            OP_JAL: begin
                dec_imm  = imm_j;
                dec_type = IMM_J;
            end
            OP_SYSTEM: begin
                // CSRR*I variants carry a 5-bit unsigned immediate in rs1.
                dec_imm  = f3[2] ? imm_csr_z : imm_i;
                dec_type = f3[2] ? IMM_CSR_Z : IMM_I;
            end
            default: begin
                dec_imm  = '0;
                dec_type = IMM_NONE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments, so every register
    // samples its inputs from before the edge, whatever the statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.immediate <= '0;
            bus.imm_type  <= IMM_NONE;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.immediate <= dec_imm;
                bus.imm_type  <= dec_type;
            end
        end
    end

endmodule

// File: tb/tb_rv64_immediate_extender.sv
// ----------------------------------------------------------------------------
// tb_rv64_immediate_extender
//   Directed test of the registered RV64I immediate generator. Each step
//   drives one instruction and compares out_valid, immediate and imm_type
//   after the next rising edge against hand-computed values.
// ----------------------------------------------------------------------------
module tb_rv64_immediate_extender;

    localparam logic [2:0] T_NONE  = 3'd0;
    localparam logic [2:0] T_I     = 3'd1;
    localparam logic [2:0] T_S     = 3'd2;
    localparam logic [2:0] T_B     = 3'd3;
    localparam logic [2:0] T_U     = 3'd4;
    localparam logic [2:0] T_J     = 3'd5;
    localparam logic [2:0] T_SHAMT = 3'd6;
    localparam logic [2:0] T_CSR_Z = 3'd7;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_fail   = 0;

    rv64_immediate_extender_if #(.XLEN(64), .ILEN(32)) bus ();

    rv64_immediate_extender #(.XLEN(64), .ILEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of input, then samples just after the capturing edge.
    task automatic step(input logic valid, input logic [31:0] word);
        @(negedge clk);
        bus.in_valid    = valid;
        bus.instruction = word;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [63:0] imm,
                              input logic [2:0] typ);
        check({tag, ".valid"}, {63'b0, bus.out_valid}, 64'd1);
        check({tag, ".imm"},   bus.immediate, imm);
        check({tag, ".type"},  {61'b0, bus.imm_type}, {61'b0, typ});
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.instruction = 32'h0;
        rst_n           = 1'b0;
        #1;
        check("rst.valid", {63'b0, bus.out_valid}, 64'd0);
        check("rst.imm",   bus.immediate, 64'd0);
        check("rst.type",  {61'b0, bus.imm_type}, 64'd0);
        #12;
        rst_n = 1'b1;

        // Unknown opcodes (op[1:0] != 11) decode to NONE with a zero immediate.
        step(1'b1, 32'h12345678); expect_out("unk0", 64'h0, T_NONE);
        step(1'b1, 32'h9ABCDEF0); expect_out("unk1", 64'h0, T_NONE);

        // Back-to-back valid words, one result per cycle.
        step(1'b1, 32'hFFF00093); expect_out("addi",  64'hFFFFFFFFFFFFFFFF, T_I);
        step(1'b1, 32'hFE112E23); expect_out("sw",    64'hFFFFFFFFFFFFFFFC, T_S);
        step(1'b1, 32'h800000B7); expect_out("lui",   64'hFFFFFFFF80000000, T_U);
        step(1'b1, 32'h008000EF); expect_out("jal",   64'h0000000000000008, T_J);
        step(1'b1, 32'h03F09093); expect_out("slli",  64'h000000000000003F, T_SHAMT);
        step(1'b1, 32'h4010D093); expect_out("srai",  64'h0000000000000001, T_SHAMT);
        // OP-IMM-32 shift with bit 25 set; only inst[24:20] contributes.
        step(1'b1, 32'h43F0D09B); expect_out("sraiw", 64'h000000000000001F, T_SHAMT);
        step(1'b1, 32'hFE000EE3); expect_out("beq",   64'hFFFFFFFFFFFFFFFC, T_B);
        step(1'b1, 32'h12345097); expect_out("auipc", 64'h0000000012345000, T_U);
        step(1'b1, 32'h3002D0F3); expect_out("csrwi", 64'h0000000000000005, T_CSR_Z);
        step(1'b1, 32'h00000073); expect_out("ecall", 64'h0, T_I);
        step(1'b1, 32'h80008067); expect_out("jalr",  64'hFFFFFFFFFFFFF800, T_I);
        step(1'b1, 32'h7FF13083); expect_out("ld",    64'h00000000000007FF, T_I);
        step(1'b1, 32'h002081B3); expect_out("add",   64'h0, T_NONE);

        // Hold: in_valid low keeps immediate/imm_type and drops out_valid.
        step(1'b1, 32'hFE112E23); expect_out("pre_hold", 64'hFFFFFFFFFFFFFFFC, T_S);
        step(1'b0, 32'h800000B7);
        check("hold.valid", {63'b0, bus.out_valid}, 64'd0);
        check("hold.imm",   bus.immediate, 64'hFFFFFFFFFFFFFFFC);
        check("hold.type",  {61'b0, bus.imm_type}, {61'b0, T_S});
        step(1'b0, 32'h008000EF);
        check("hold2.imm",  bus.immediate, 64'hFFFFFFFFFFFFFFFC);

        // Asynchronous reset mid-cycle takes effect without a clock edge.
        step(1'b1, 32'h800000B7); expect_out("pre_rst", 64'hFFFFFFFF80000000, T_U);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.valid", {63'b0, bus.out_valid}, 64'd0);
        check("arst.imm",   bus.immediate, 64'd0);
        check("arst.type",  {61'b0, bus.imm_type}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First capture after release.
        step(1'b1, 32'h03F09093); expect_out("post_rst", 64'h000000000000003F, T_SHAMT);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
